// File: rtl/pixel_shuffle_pkg.sv
// Constants and index helper shared by the r=2 pixel shuffle and unshuffle stages.
// A raster pixel p=y*4+x lands at channel-major index k=c*4+h*2+w.
package pixel_shuffle_pkg;

    localparam int R    = 2;
    localparam int TILE = 4;
    localparam int NPIX = TILE * TILE;
    localparam int NCH  = R * R;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

    // c=(y%2)*2+(x%2), h=y/2, w=x/2, so k is just the bits {y0, x0, y1, x1}.
    function automatic logic [3:0] unshuffle_idx(input logic [3:0] p);
        logic [1:0] y;
        logic [1:0] x;
        y = p[3:2];
        x = p[1:0];
        return {y[0], x[0], y[1], x[1]};
    endfunction

endpackage

// File: rtl/pixel_unshuffle_stream_if.sv
// Pixel-in / tile-out stream bundle for pixel_unshuffle_stream.
// slave is the block's view, master is the view of whatever drives it.
interface pixel_unshuffle_stream_if #(
    parameter int DATA_W = 8
);
    logic                                       s_valid;
    logic                                       s_ready;
    logic [DATA_W-1:0]                          s_data;
    logic                                       s_last;
    logic                                       m_valid;
    logic                                       m_ready;
    logic [pixel_shuffle_pkg::NPIX*DATA_W-1:0]  m_data;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/pixel_unshuffle_buf.sv
// One 16-entry tile buffer: indexed pixel write, whole-tile flat read, and a full flag
// that marks a completed tile until the consumer releases it.
module pixel_unshuffle_buf
    import pixel_shuffle_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [3:0]             wr_idx,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   set_full,
    input  logic                   clr_full,
    output logic [NPIX*DATA_W-1:0] rd_data,
    output logic                   full
);

    logic [DATA_W-1:0] mem_q [NPIX];
    logic              full_q;

    // Contents are cleared on reset because the whole tile is visible on m_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPIX; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
        end else if (set_full) begin
            full_q <= 1'b1;
        end else if (clr_full) begin
            full_q <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NPIX; gi++) begin : g_rd
            assign rd_data[gi*DATA_W +: DATA_W] = mem_q[gi];
        end
    endgenerate

    assign full = full_q;

endmodule

// File: rtl/pixel_unshuffle_stream.sv
// Space-to-depth (r=2) converter: a 4x4 raster tile in, one 16-pixel channel-major word out.
// Define PIXEL_UNSHUFFLE_PINGPONG_EN for two tile buffers so collection overlaps the output wait.
module pixel_unshuffle_stream
    import pixel_shuffle_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    pixel_unshuffle_stream_if.slave        bus,
    output logic [15:0]                    tile_count,
    output logic                           err_framing
);

`ifdef PIXEL_UNSHUFFLE_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic                   s_ready;
    logic                   m_valid;
    logic                   accept;
    logic                   last_pix;
    logic                   early_last;
    logic                   tile_done;
    logic                   m_fire;

    logic [3:0]             cnt_q, cnt_d;
    logic [15:0]            tile_count_q, tile_count_d;
    logic                   err_q, err_d;

    logic [NBUF-1:0]        buf_wr;
    logic [NBUF-1:0]        buf_set;
    logic [NBUF-1:0]        buf_clr;
    logic [NBUF-1:0]        buf_full;
    logic [NPIX*DATA_W-1:0] buf_data [NBUF];

    assign accept     = bus.s_valid && s_ready;
    assign last_pix   = (cnt_q == 4'd15);
    assign early_last = accept && bus.s_last && !last_pix;
    assign tile_done  = accept && last_pix;
    assign m_fire     = m_valid && bus.m_ready;

    // A premature s_last drops the partial tile; a missing one is flagged but still emitted.
    always_comb begin
        cnt_d        = cnt_q;
        tile_count_d = tile_count_q + 16'(m_fire);
        err_d        = err_q | early_last | (tile_done && !bus.s_last);
        if (early_last) begin
            cnt_d = 4'd0;
        end else if (accept) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 4'd0;
            tile_count_q <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tile_count_q <= tile_count_d;
            err_q        <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
            pixel_unshuffle_buf #(
                .DATA_W   (DATA_W)
            ) u_buf (
                .clk      (clk),
                .rst      (rst),
                .wr_en    (buf_wr[gi]),
                .wr_idx   (unshuffle_idx(cnt_q)),
                .wr_data  (bus.s_data),
                .set_full (buf_set[gi]),
                .clr_full (buf_clr[gi]),
                .rd_data  (buf_data[gi]),
                .full     (buf_full[gi])
            );
        end
    endgenerate

`ifdef PIXEL_UNSHUFFLE_PINGPONG_EN
    logic wr_sel_q, wr_sel_d;
    logic rd_sel_q, rd_sel_d;

    // Buffers fill and drain in strict alternation, which keeps the output FIFO-ordered.
    always_comb begin
        wr_sel_d = wr_sel_q ^ tile_done;
        rd_sel_d = rd_sel_q ^ m_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NBUF; gi++) begin : g_sel
            assign buf_wr[gi]  = accept    && (wr_sel_q == 1'(gi));
            assign buf_set[gi] = tile_done && (wr_sel_q == 1'(gi));
            assign buf_clr[gi] = m_fire    && (rd_sel_q == 1'(gi));
        end
    endgenerate

    assign s_ready    = !buf_full[wr_sel_q];
    assign m_valid    = buf_full[rd_sel_q];
    assign bus.m_data = buf_data[rd_sel_q];
`else
    state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (tile_done) state_d = EMIT;
            EMIT:    if (m_fire)    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        s_ready = (state_q == COLLECT);
        m_valid = (state_q == EMIT) && buf_full[0];
    end

    assign buf_wr[0]  = accept;
    assign buf_set[0] = tile_done;
    assign buf_clr[0] = m_fire;
    assign bus.m_data = buf_data[0];
`endif

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid;
    assign tile_count   = tile_count_q;
    assign err_framing  = err_q;

endmodule

// File: tb/tb_pixel_unshuffle_stream.sv
// Testbench for pixel_unshuffle_stream (either build of PIXEL_UNSHUFFLE_PINGPONG_EN).
module tb_pixel_unshuffle_stream;
    import pixel_shuffle_pkg::*;

    localparam int DW = 8;

`ifdef PIXEL_UNSHUFFLE_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tile_count;
    logic        err_framing;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_count;

    typedef struct {
        logic [127:0] tile;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    pixel_unshuffle_stream_if #(.DATA_W(DW)) bus ();

    pixel_unshuffle_stream #(
        .DATA_W      (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tile_count  (tile_count),
        .err_framing (err_framing)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // Space-to-depth straight from the geometry: pixel (y,x) -> channel (y%2,x%2), site (y/2,x/2).
    function automatic logic [127:0] ref_unshuffle(input logic [127:0] t);
        logic [127:0] o;
        int c, k;
        o = '0;
        for (int y = 0; y < TILE; y++) begin
            for (int x = 0; x < TILE; x++) begin
                c = (y % 2) * 2 + (x % 2);
                k = c * 4 + (y / 2) * 2 + (x / 2);
                o[k*8 +: 8] = t[(y*4 + x)*8 +: 8];
            end
        end
        return o;
    endfunction

    // Depth-to-space, the downstream shuffle stage: channel c, site (h,w) -> pixel (2h+c/2, 2w+c%2).
    function automatic logic [127:0] ref_shuffle(input logic [127:0] m);
        logic [127:0] o;
        int y, x;
        o = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int h = 0; h < 2; h++) begin
                for (int w = 0; w < 2; w++) begin
                    y = 2 * h + c / 2;
                    x = 2 * w + c % 2;
                    o[(y*4 + x)*8 +: 8] = m[(c*4 + h*2 + w)*8 +: 8];
                end
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check({tag, "_s_ready"},    128'(bus.s_ready),   128'd1);
        check({tag, "_m_valid"},    128'(bus.m_valid),   128'd0);
        check({tag, "_m_data"},     bus.m_data,          128'd0);
        check({tag, "_tile_count"}, 128'(tile_count),    128'd0);
        check({tag, "_err"},        128'(err_framing),   128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_count = 16'd0;
    endtask

    task automatic send_pix(input logic [7:0] d, input logic last, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        t = 0;
        while (!bus.s_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_wait: got 0 after %0d cycles, expected 1", t);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_tile(input logic [127:0] t, input int last_at, input bit gaps);
        for (int p = 0; p < NPIX; p++) begin
            send_pix(t[p*8 +: 8], p == last_at, gaps);
        end
    endtask

    task automatic take_tile(output logic [127:0] got);
        int t;
        logic seen;
        t = 0;
        while (!bus.m_valid && t < 64) begin
            @(posedge clk); #1;
            t++;
        end
        seen = bus.m_valid;
        check("m_valid_wait", 128'(seen), 128'd1);
        got = bus.m_data;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        if (seen) exp_count++;
        $display("tile %0d out: %h", exp_count, got);
        check("tile_count", 128'(tile_count), 128'(exp_count));
    endtask

    initial begin
        logic [127:0] got, held, rt;

        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        exp_count   = 16'd0;

        vecs[0] = '{tile: 128'h0F0E0D0C0B0A09080706050403020100,
                    exp:  128'h0F0D07050E0C06040B0903010A080200};
        vecs[1] = '{tile: {16{8'hFF}}, exp: {16{8'hFF}}};
        vecs[2] = '{tile: (128'hAA << 40) | (128'h33 << 80) | (128'h5A << 120),
                    exp:  (128'hAA << 96) | (128'h33 << 24) | (128'h5A << 120)};
        vecs[3] = '{tile: (128'h77 << 24) | (128'h11 << 96),
                    exp:  (128'h77 << 40) | (128'h11 << 80)};

        repeat (2) @(posedge clk);
        #1;
        do_reset("init");

        // Directed tiles: 1-cycle latency, packing, count.
        for (int v = 0; v < 4; v++) begin
            send_tile(vecs[v].tile, 15, 1'b0);
            check("latency_m_valid", 128'(bus.m_valid), 128'd1);
            take_tile(got);
            check($sformatf("vec%0d_data", v), got, vecs[v].exp);
            check("after_take_s_ready", 128'(bus.s_ready), 128'd1);
            check("after_take_m_valid", 128'(bus.m_valid), 128'd0);
        end

        // Output held for 5 cycles while m_ready is low.
        rt = {$urandom, $urandom, $urandom, $urandom};
        send_tile(rt, 15, 1'b0);
        held = bus.m_data;
        for (int i = 0; i < 5; i++) begin
            check("stall_m_valid", 128'(bus.m_valid), 128'd1);
            check("stall_m_data",  bus.m_data,        held);
            check("stall_s_ready", 128'(bus.s_ready), 128'(PP));
            @(posedge clk); #1;
        end
        take_tile(got);
        check("stall_data", got, ref_unshuffle(rt));
        check("stall_release_s_ready", 128'(bus.s_ready), 128'd1);

        // Missing s_last on the 16th pixel: flagged, tile still emitted.
        rt = {$urandom, $urandom, $urandom, $urandom};
        send_tile(rt, -1, 1'b0);
        check("nolast_err", 128'(err_framing), 128'd1);
        take_tile(got);
        check("nolast_data", got, ref_unshuffle(rt));

        // Early s_last on the 7th pixel: flagged, partial tile dropped.
        do_reset("pre_early");
        for (int p = 0; p < 7; p++) begin
            send_pix(8'(8'hC0 + p), p == 6, 1'b0);
        end
        check("early_err", 128'(err_framing), 128'd1);
        for (int i = 0; i < 3; i++) begin
            check("early_no_m_valid", 128'(bus.m_valid), 128'd0);
            @(posedge clk); #1;
        end
        rt = {$urandom, $urandom, $urandom, $urandom};
        send_tile(rt, 15, 1'b0);
        take_tile(got);
        check("early_next_data", got, ref_unshuffle(rt));
        check("early_err_sticky", 128'(err_framing), 128'd1);

        // Reset after 9 pixels, then a clean tile.
        for (int p = 0; p < 9; p++) begin
            send_pix(8'(8'hE0 + p), 1'b0, 1'b0);
        end
        do_reset("mid_tile");
        rt = {$urandom, $urandom, $urandom, $urandom};
        send_tile(rt, 15, 1'b0);
        take_tile(got);
        check("mid_tile_data", got, ref_unshuffle(rt));
        check("mid_tile_err", 128'(err_framing), 128'd0);

        // Reset while a tile is waiting for m_ready: it must never appear.
        send_tile(rt, 15, 1'b0);
        check("mid_emit_m_valid_pre", 128'(bus.m_valid), 128'd1);
        do_reset("mid_emit");
        repeat (3) @(posedge clk);
        #1;
        check("mid_emit_no_m_valid", 128'(bus.m_valid), 128'd0);

        // Random tiles with input gaps and output back-pressure, checked by round trip.
        for (int n = 0; n < 1000; n++) begin
            rt = {$urandom, $urandom, $urandom, $urandom};
            send_tile(rt, 15, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            take_tile(got);
            check("round_trip", ref_shuffle(got), rt);
        end

`ifdef PIXEL_UNSHUFFLE_PINGPONG_EN
        begin
            logic [127:0] pp_tiles [4];
            int  pi, got_n, last_cyc;
            logic mv, sr;
            logic [127:0] md;
            for (int i = 0; i < 4; i++) pp_tiles[i] = {$urandom, $urandom, $urandom, $urandom};
            pi = 0;
            got_n = 0;
            last_cyc = -1;
            bus.m_ready = 1'b1;
            for (int cyc = 0; cyc < 90 && got_n < 4; cyc++) begin
                if (pi < 64) begin
                    bus.s_valid = 1'b1;
                    bus.s_data  = pp_tiles[pi / 16][(pi % 16)*8 +: 8];
                    bus.s_last  = (pi % 16 == 15);
                    check("pp_s_ready", 128'(bus.s_ready), 128'd1);
                end else begin
                    bus.s_valid = 1'b0;
                    bus.s_last  = 1'b0;
                end
                mv = bus.m_valid;
                sr = bus.s_ready;
                md = bus.m_data;
                @(posedge clk); #1;
                if (pi < 64 && sr) pi++;
                if (mv) begin
                    check($sformatf("pp_tile%0d", got_n), md, ref_unshuffle(pp_tiles[got_n]));
                    got_n++;
                    exp_count++;
                    last_cyc = cyc;
                    $display("pingpong tile %0d out at cycle %0d", got_n, cyc);
                end
            end
            bus.s_valid = 1'b0;
            bus.m_ready = 1'b0;
            check("pp_tiles_out", 128'(got_n), 128'd4);
            check("pp_last_cycle", 128'(last_cyc), 128'd64);
            check("pp_tile_count", 128'(tile_count), 128'(exp_count));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
